// File: rtl/fir_sweep_sequencer.sv
// Section-by-section amplitude sweep sequencer for a pipelined FIR filter:
// fetch one stimulus sample, settle, track the signed output peak, report it.
module fir_sweep_sequencer #(
  parameter int DATA_W        = 16,
  parameter int ACC_W         = 40,
  parameter int NUM_SECTIONS  = 26,
  parameter int SETTLE_CYCLES = 170,
  parameter int WINDOW_CYCLES = 2000,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  input  logic                     stim_valid,
  output logic                     stim_ready,
  input  logic signed [DATA_W-1:0] stim_data,
  output logic signed [DATA_W-1:0] fir_inp,
  input  logic signed [ACC_W-1:0]  fir_outp,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_section,
  output logic signed [ACC_W-1:0]  res_peak
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETTLE,
    S_MEASURE,
    S_REPORT
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [7:0]       LAST_SECTION = 8'(NUM_SECTIONS);

  state_t                    state_q, state_d;
  logic [7:0]                section_q, section_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   peak_q, peak_d;
  logic signed [DATA_W-1:0]  fir_inp_q, fir_inp_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      stim_ready_q, stim_ready_d;
  logic                      res_valid_q, res_valid_d;
  logic [7:0]                res_section_q, res_section_d;
  logic signed [ACC_W-1:0]   res_peak_q, res_peak_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    section_d     = section_q;
    cnt_d         = cnt_q;
    peak_d        = peak_q;
    fir_inp_d     = fir_inp_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    stim_ready_d  = stim_ready_q;
    res_valid_d   = res_valid_q;
    res_section_d = res_section_q;
    res_peak_d    = res_peak_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          section_d    = 8'd1;
          busy_d       = 1'b1;
          stim_ready_d = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_FETCH: begin
        if (stim_valid && stim_ready_q) begin
          fir_inp_d    = stim_data;
          cnt_d        = '0;
          stim_ready_d = 1'b0;
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_MEASURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MEASURE: begin
        // NOTE: blocking '=' in combinational logic lets the report below see
        // the peak that already includes this cycle's sample.
        if (cnt_q == '0 || fir_outp > peak_q) peak_d = fir_outp;
        if (cnt_q == WINDOW_LAST) begin
          res_peak_d    = peak_d;
          res_section_d = section_q;
          res_valid_d   = 1'b1;
          cnt_d         = '0;
          state_d       = S_REPORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REPORT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          if (section_q == LAST_SECTION) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            section_d    = section_q + 8'd1;
            stim_ready_d = 1'b1;
            state_d      = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any in-flight handshake; the last result stays visible.
    if (abort && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      fir_inp_d    = '0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      stim_ready_d = 1'b0;
      res_valid_d  = 1'b0;
    end
  end

  // NOTE: state and result registers are all explicit flops (no memories), so
  // every one is cleared by reset and the post-reset outputs are fully defined.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      section_q     <= '0;
      cnt_q         <= '0;
      peak_q        <= '0;
      fir_inp_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      stim_ready_q  <= 1'b0;
      res_valid_q   <= 1'b0;
      res_section_q <= '0;
      res_peak_q    <= '0;
    end else begin
      state_q       <= state_d;
      section_q     <= section_d;
      cnt_q         <= cnt_d;
      peak_q        <= peak_d;
      fir_inp_q     <= fir_inp_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      stim_ready_q  <= stim_ready_d;
      res_valid_q   <= res_valid_d;
      res_section_q <= res_section_d;
      res_peak_q    <= res_peak_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign stim_ready  = stim_ready_q;
  assign fir_inp     = fir_inp_q;
  assign res_valid   = res_valid_q;
  assign res_section = res_section_q;
  assign res_peak    = res_peak_q;

endmodule
